// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD refresh controller.
// Holds the HD44780 command bytes, the sequencer state encoding and the
// common timer width, plus the lookup for the power-up command list.
package lcd_pkg;

  // Wide enough for the longest wait (power-up idle and Clear Display).
  localparam int CNT_W = 20;

  localparam logic [7:0] CMD_FUNCSET = 8'h38; // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] CMD_DISPON  = 8'h0C; // display on, cursor off
  localparam logic [7:0] CMD_CLEAR   = 8'h01; // clear display (slow command)
  localparam logic [7:0] CMD_ENTRY   = 8'h06; // entry mode: increment
  localparam logic [7:0] CMD_LINE1   = 8'h80; // DDRAM address 0x00
  localparam logic [7:0] CMD_LINE2   = 8'hC0; // DDRAM address 0x40

  // Index of the final entry of the power-up command list.
  localparam logic [2:0] INIT_LAST = 3'd6;

  typedef enum logic [2:0] {
    PWR_WAIT,
    INIT,
    ADDR1,
    ADDR2,
    DATA
  } state_t;

  // Power-up command list: four function sets, display on, clear, entry mode.
  function automatic logic [7:0] init_cmd(input logic [2:0] step);
    case (step)
      3'd0, 3'd1, 3'd2, 3'd3: init_cmd = CMD_FUNCSET;
      3'd4:                   init_cmd = CMD_DISPON;
      3'd5:                   init_cmd = CMD_CLEAR;
      default:                init_cmd = CMD_ENTRY;
    endcase
  endfunction

endpackage

// File: rtl/lcd_bus_write.sv
// Purpose: one HD44780 write cycle - setup, E pulse, hold, then execution wait.
// Latency: E rises T_SETUP cycles after start; done is high in the last wait cycle.
// Backpressure: start is honoured only when idle or in the done cycle (back-to-back).
// Ports: start/rs/data_byte/is_clear request a write; lcd_rs/lcd_e/lcd_db drive the
// panel (all registered); done flags completion combinationally from the timer.
module lcd_bus_write import lcd_pkg::*; #(
  parameter int T_SETUP = 4,
  parameter int T_EPW   = 16,
  parameter int T_HOLD  = 4,
  parameter int T_EXEC  = 2500,
  parameter int T_CLEAR = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data_byte,
  input  logic       is_clear,
  output logic       lcd_rs,
  output logic       lcd_e,
  output logic [7:0] lcd_db,
  output logic       done
);

  typedef enum logic [2:0] {B_IDLE, B_SETUP, B_PULSE, B_HOLD, B_WAIT} phase_t;

  phase_t           phase;
  logic [CNT_W-1:0] cnt;
  logic             clr;
  logic [CNT_W-1:0] wait_last;
  logic             load;

  assign wait_last = clr ? CNT_W'(T_CLEAR - 1) : CNT_W'(T_EXEC - 1);
  assign done      = (phase == B_WAIT) && (cnt == wait_last);
  // Accepting a new byte in the done cycle keeps consecutive commands gap-free.
  assign load      = start && ((phase == B_IDLE) || done);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase  <= B_IDLE;
      cnt    <= '0;
      clr    <= 1'b0;
      lcd_rs <= 1'b0;
      lcd_e  <= 1'b0;
      lcd_db <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
      case (phase)
        B_IDLE: cnt <= '0;
        B_SETUP:
          if (cnt == CNT_W'(T_SETUP - 1)) begin
            lcd_e <= 1'b1;
            phase <= B_PULSE;
            cnt   <= '0;
          end
        B_PULSE:
          if (cnt == CNT_W'(T_EPW - 1)) begin
            lcd_e <= 1'b0;
            phase <= B_HOLD;
            cnt   <= '0;
          end
        B_HOLD:
          if (cnt == CNT_W'(T_HOLD - 1)) begin
            phase <= B_WAIT;
            cnt   <= '0;
          end
        B_WAIT:
          if (done) begin
            phase <= B_IDLE;
            cnt   <= '0;
          end
        default: phase <= B_IDLE;
      endcase
      // RS/DB only ever change here, i.e. never while E is high or holding.
      if (load) begin
        lcd_rs <= rs;
        lcd_db <= data_byte;
        clr    <= is_clear;
        phase  <= B_SETUP;
        cnt    <= '0;
      end
    end
  end

endmodule

// File: rtl/lcd_refresh_ctrl.sv
// Purpose: HD44780 16x2 power-up sequencer followed by continuous screen refresh.
// Latency: char_in is sampled FETCH_LAT cycles after index changes; no gap between frames.
// Backpressure: none; the panel timing is fixed and upstream must follow index.
// Ports: char_in is the registered byte for index; lcd_* drive the panel (write only);
// init_done stays high after power-up; frame_done pulses once after position 31.
module lcd_refresh_ctrl import lcd_pkg::*; #(
  parameter int T_PWRUP   = 750000,
  parameter int T_SETUP   = 4,
  parameter int T_EPW     = 16,
  parameter int T_HOLD    = 4,
  parameter int T_EXEC    = 2500,
  parameter int T_CLEAR   = 100000,
  parameter int FETCH_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] char_in,
  output logic [4:0] index,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_db,
  output logic       init_done,
  output logic       frame_done
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       step;
  logic             fetching;

  logic             start;
  logic             wr_rs;
  logic [7:0]       wr_byte;
  logic             wr_done;
  logic             pwr_last;
  logic             fetch_last;

  assign lcd_rw     = 1'b0;
  assign pwr_last   = (cnt == CNT_W'(T_PWRUP - 1));
  assign fetch_last = fetching && (cnt == CNT_W'(FETCH_LAT - 1));

  // Each state's command is launched on the cycle that enters it, so the state
  // means "this command is in flight" and no bus cycle is lost between bytes.
  always_comb begin
    start   = 1'b0;
    wr_rs   = 1'b0;
    wr_byte = CMD_FUNCSET;
    case (state)
      PWR_WAIT: start = pwr_last;
      INIT:
        if (wr_done) begin
          start   = 1'b1;
          wr_byte = (step == INIT_LAST) ? CMD_LINE1 : init_cmd(step + 3'd1);
        end
      DATA:
        if (fetch_last) begin
          start   = 1'b1;
          wr_rs   = 1'b1;
          wr_byte = char_in;
        end else if (wr_done && (index == 5'd15)) begin
          start   = 1'b1;
          wr_byte = CMD_LINE2;
        end else if (wr_done && (index == 5'd31)) begin
          start   = 1'b1;
          wr_byte = CMD_LINE1;
        end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= PWR_WAIT;
      cnt        <= '0;
      step       <= '0;
      fetching   <= 1'b0;
      index      <= '0;
      init_done  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        PWR_WAIT:
          if (pwr_last) begin
            state <= INIT;
            step  <= '0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        INIT:
          if (wr_done) begin
            if (step == INIT_LAST) begin
              init_done <= 1'b1;
              index     <= '0;
              state     <= ADDR1;
            end else begin
              step <= step + 3'd1;
            end
          end
        ADDR1, ADDR2:
          if (wr_done) begin
            state    <= DATA;
            fetching <= 1'b1;
            cnt      <= '0;
          end
        DATA:
          if (fetching) begin
            // Give the upstream register FETCH_LAT cycles to follow index.
            if (fetch_last) begin
              fetching <= 1'b0;
              cnt      <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end else if (wr_done) begin
            if (index == 5'd15) begin
              index <= 5'd16;
              state <= ADDR2;
            end else if (index == 5'd31) begin
              index      <= '0;
              frame_done <= 1'b1;
              state      <= ADDR1;
            end else begin
              index    <= index + 5'd1;
              fetching <= 1'b1;
              cnt      <= '0;
            end
          end
        default: state <= PWR_WAIT;
      endcase
    end
  end

  lcd_bus_write #(
    .T_SETUP (T_SETUP),
    .T_EPW   (T_EPW),
    .T_HOLD  (T_HOLD),
    .T_EXEC  (T_EXEC),
    .T_CLEAR (T_CLEAR)
  ) u_bus (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rs        (wr_rs),
    .data_byte (wr_byte),
    .is_clear  (!wr_rs && (wr_byte == CMD_CLEAR)),
    .lcd_rs    (lcd_rs),
    .lcd_e     (lcd_e),
    .lcd_db    (lcd_db),
    .done      (wr_done)
  );

endmodule

// File: tb/tb_lcd_refresh_ctrl.sv
// Directed bench for lcd_refresh_ctrl with shortened panel timings.
module tb_lcd_refresh_ctrl;

  localparam int T_PWRUP = 20, T_SETUP = 1, T_EPW = 2, T_HOLD = 1;
  localparam int T_EXEC = 5, T_CLEAR = 10, FETCH_LAT = 2;
  // E-rise to E-rise spacing: command = 1+2+1+5, clear = 1+2+1+10, data adds fetch.
  localparam int CMD_GAP = 9, CLR_GAP = 14, DATA_GAP = 11;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] char_in = 8'h00;
  logic [4:0] index;
  logic       lcd_rs, lcd_rw, lcd_e, init_done, frame_done;
  logic [7:0] lcd_db;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  lcd_refresh_ctrl #(
    .T_PWRUP(T_PWRUP), .T_SETUP(T_SETUP), .T_EPW(T_EPW), .T_HOLD(T_HOLD),
    .T_EXEC(T_EXEC), .T_CLEAR(T_CLEAR), .FETCH_LAT(FETCH_LAT)
  ) dut (
    .clk(clk), .rst(rst), .char_in(char_in), .index(index),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_db(lcd_db),
    .init_done(init_done), .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Upstream display list: index+0x41 with one register stage; position 5 can be overridden.
  logic       ovr_en = 1'b0;
  logic [7:0] ovr_val = 8'h00;
  always @(posedge clk)
    char_in <= (ovr_en && index == 5'd5) ? ovr_val : 8'h41 + {3'b000, index};

  // Bus monitor: log every E rise, count frame_done pulses and bus-stability violations.
  logic [7:0] ev_db[$];
  logic       ev_rs[$];
  logic       ev_init[$];
  int         ev_cyc[$];
  int         fd_cyc[$];
  int         fd_high = 0, bus_bad = 0, rw_bad = 0;
  logic       prev_e = 1'b0, prev_rs = 1'b0, prev_fd = 1'b0;
  logic [7:0] prev_db = 8'h00;

  always @(negedge clk) begin
    if (!rst) begin
      prev_e  <= 1'b0;
      prev_fd <= 1'b0;
    end else begin
      if (lcd_rw !== 1'b0) rw_bad <= rw_bad + 1;
      if ((lcd_e || prev_e) && (lcd_db !== prev_db || lcd_rs !== prev_rs))
        bus_bad <= bus_bad + 1;
      if (lcd_e && !prev_e) begin
        ev_db.push_back(lcd_db);
        ev_rs.push_back(lcd_rs);
        ev_init.push_back(init_done);
        ev_cyc.push_back(cyc);
      end
      if (frame_done) fd_high <= fd_high + 1;
      if (frame_done && !prev_fd) fd_cyc.push_back(cyc);
      prev_e  <= lcd_e;
      prev_rs <= lcd_rs;
      prev_db <= lcd_db;
      prev_fd <= frame_done;
    end
  end

  int base;      // first event of the current power-up
  int rel;       // cycle count at reset release
  logic [7:0] init_seq [8] = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06, 8'h80};

  task automatic wait_events(input int n);
    int t = 0;
    while (ev_cyc.size() < base + n && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (ev_cyc.size() < base + n) begin
      $display("FAIL wait_events: got %0d E pulses, need %0d", ev_cyc.size() - base, n);
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "timeout");
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (index !== 5'd0) begin errors++; $display("FAIL reset_index got %0d want 0", index); end
    checks++; if (lcd_e !== 1'b0) begin errors++; $display("FAIL reset_e got %b want 0", lcd_e); end
    checks++; if (lcd_db !== 8'h00 || lcd_rs !== 1'b0 || lcd_rw !== 1'b0) begin
      errors++; $display("FAIL reset_bus got db=%h rs=%b rw=%b want 00/0/0", lcd_db, lcd_rs, lcd_rw);
    end
    checks++; if (init_done !== 1'b0 || frame_done !== 1'b0) begin
      errors++; $display("FAIL reset_flags got init=%b frame=%b want 0/0", init_done, frame_done);
    end
  endtask

  // Release reset and check the power-up timing and command list up to the line-1 address.
  task automatic run_init(input string tag);
    base = ev_cyc.size();
    @(negedge clk);
    rst = 1'b1;
    rel = cyc;
    wait_events(8);
    checks++;
    if (ev_cyc[base] - rel != T_PWRUP + T_SETUP) begin
      errors++; $display("FAIL %s first_e at %0d cycles want %0d", tag, ev_cyc[base] - rel, T_PWRUP + T_SETUP);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (ev_db[base+i] !== init_seq[i] || ev_rs[base+i] !== 1'b0) begin
        errors++; $display("FAIL %s cmd%0d got %h rs=%b want %h rs=0", tag, i, ev_db[base+i], ev_rs[base+i], init_seq[i]);
      end
    end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (ev_cyc[base+i+1] - ev_cyc[base+i] != ((i == 5) ? CLR_GAP : CMD_GAP)) begin
        errors++; $display("FAIL %s gap%0d got %0d want %0d", tag, i, ev_cyc[base+i+1] - ev_cyc[base+i], (i == 5) ? CLR_GAP : CMD_GAP);
      end
    end
    checks++;
    if (ev_init[base+6] !== 1'b0 || ev_init[base+7] !== 1'b1) begin
      errors++; $display("FAIL %s init_done got %b/%b want 0/1", tag, ev_init[base+6], ev_init[base+7]);
    end
  endtask

  task automatic test_init;
    run_init("init");
  endtask

  // Two full frames plus the start of the third: byte order, RS, spacing, frame_done.
  task automatic test_back_to_back;
    int pos, wgap;
    logic [7:0] wdb;
    logic wrs;
    wait_events(7 + 68 + 1);
    for (int i = 0; i < 68; i++) begin
      pos = i % 34;
      if (pos == 0)       begin wdb = 8'h80; wrs = 1'b0; end
      else if (pos <= 16) begin wdb = 8'h41 + 8'(pos - 1); wrs = 1'b1; end
      else if (pos == 17) begin wdb = 8'hC0; wrs = 1'b0; end
      else                begin wdb = 8'h51 + 8'(pos - 18); wrs = 1'b1; end
      wgap = (pos == 16 || pos == 33) ? CMD_GAP : DATA_GAP;
      checks++;
      if (ev_db[base+7+i] !== wdb || ev_rs[base+7+i] !== wrs) begin
        errors++; $display("FAIL frame_byte%0d got %h rs=%b want %h rs=%b", i, ev_db[base+7+i], ev_rs[base+7+i], wdb, wrs);
      end
      checks++;
      if (ev_cyc[base+8+i] - ev_cyc[base+7+i] != wgap) begin
        errors++; $display("FAIL frame_gap%0d got %0d want %0d", i, ev_cyc[base+8+i] - ev_cyc[base+7+i], wgap);
      end
    end
    checks++;
    if (ev_cyc[base+41] - ev_cyc[base+7] != 370) begin
      errors++; $display("FAIL frame_period got %0d want 370", ev_cyc[base+41] - ev_cyc[base+7]);
    end
    checks++;
    if (fd_cyc.size() != 2 || fd_high != 2) begin
      errors++; $display("FAIL frame_done_count got %0d pulses %0d high cycles want 2/2", fd_cyc.size(), fd_high);
    end else begin
      checks++;
      if (fd_cyc[0] != ev_cyc[base+41] - 1 || fd_cyc[1] != ev_cyc[base+75] - 1) begin
        errors++; $display("FAIL frame_done_time got %0d,%0d want %0d,%0d", fd_cyc[0], fd_cyc[1], ev_cyc[base+41] - 1, ev_cyc[base+75] - 1);
      end
    end
    checks++;
    if (index !== 5'd0) begin errors++; $display("FAIL wrap_index got %0d want 0", index); end
  endtask

  // Position 5 changes after frame 3 has written it: frame 3 keeps the old byte, frame 4 shows the new one.
  task automatic test_char_update;
    wait_events(7 + 68 + 7);
    ovr_val = 8'h7A;
    ovr_en  = 1'b1;
    wait_events(7 + 102 + 8);
    checks++;
    if (ev_db[base+81] !== 8'h46 || ev_db[base+82] !== 8'h47) begin
      errors++; $display("FAIL update_same_frame got %h,%h want 46,47", ev_db[base+81], ev_db[base+82]);
    end
    checks++;
    if (ev_db[base+115] !== 8'h7A) begin
      errors++; $display("FAIL update_next_frame got %h want 7a", ev_db[base+115]);
    end
    checks++;
    if (ev_db[base+114] !== 8'h45 || ev_db[base+116] !== 8'h47) begin
      errors++; $display("FAIL update_neighbours got %h,%h want 45,47", ev_db[base+114], ev_db[base+116]);
    end
  endtask

  task automatic test_bus_monitor;
    checks++;
    if (bus_bad != 0) begin errors++; $display("FAIL bus_stable got %0d changes want 0", bus_bad); end
    checks++;
    if (rw_bad != 0) begin errors++; $display("FAIL rw_low got %0d high samples want 0", rw_bad); end
  endtask

  // Reset while E is high during a data write, then the full power-up must repeat.
  task automatic test_reset_mid;
    int t = 0;
    while (!(lcd_e && lcd_rs) && t < 200) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (!(lcd_e && lcd_rs)) begin errors++; $display("FAIL mid_data_e got e=%b rs=%b want 1/1", lcd_e, lcd_rs); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (lcd_e !== 1'b0 || lcd_db !== 8'h00 || index !== 5'd0 || init_done !== 1'b0) begin
      errors++; $display("FAIL mid_reset got e=%b db=%h idx=%0d init=%b want 0/00/0/0", lcd_e, lcd_db, index, init_done);
    end
    repeat (2) @(negedge clk);
    run_init("reinit");
  endtask

  initial begin
    test_reset;
    test_init;
    test_back_to_back;
    test_char_update;
    test_bus_monitor;
    test_reset_mid;
    test_bus_monitor;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_refresh_ctrl.md
Name: lcd_refresh_ctrl

Overview:
- Drives a 16x2 HD44780-compatible character LCD over an 8-bit parallel bus (write-only).
- Runs the power-up initialisation sequence, then refreshes the screen continuously.
- Each refresh walks a 5-bit character index 0..31 and writes the returned ASCII byte to DDRAM.
- Sits directly downstream of the display-list stage. It produces `index` and consumes the registered character byte that comes back.

Parameters:
- T_PWRUP, 750000: clk cycles of idle after reset before the first command (15 ms at 50 MHz).
- T_SETUP, 4: cycles RS/DB are held stable before E rises.
- T_EPW, 16: cycles E is held high.
- T_HOLD, 4: cycles RS/DB are held after E falls.
- T_EXEC, 2500: wait cycles after an ordinary command or data write (50 us).
- T_CLEAR, 100000: wait cycles after Clear Display (2 ms).
- FETCH_LAT, 2: cycles between an `index` change and a valid `char_in`.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous reset, active-low.
- char_in, input, 8: ASCII byte for the current index, registered upstream.
- index, output, 5: character position (0..15 = line 1, 16..31 = line 2).
- lcd_rs, output, 1: register select (0 = command, 1 = data).
- lcd_rw, output, 1: read/write; tied to 0 (write only).
- lcd_e, output, 1: enable strobe.
- lcd_db, output, 8: data bus.
- init_done, output, 1: high once initialisation completes; stays high until reset.
- frame_done, output, 1: one-cycle pulse after the write of index 31 completes.

Behaviour:
- Reset values, asynchronous, taking effect immediately even mid-cycle:
  - index, lcd_rs, lcd_rw, lcd_e, lcd_db, init_done, frame_done = 0.
  - FSM returns to PWR_WAIT; all counters clear.
- Reset asserted mid-transfer aborts the transfer. E drops the same cycle; no partial state survives.
- Bus write cycle, used for every byte:
  - Drive RS and DB, wait T_SETUP.
  - E = 1 for T_EPW.
  - E = 0, hold RS/DB for T_HOLD.
  - Wait T_EXEC, or T_CLEAR if the byte was command 0x01.
  - Total cost = T_SETUP + T_EPW + T_HOLD + wait.
  - RS and DB must not change while E is high or during T_HOLD.
- FSM states and transitions:
  - PWR_WAIT: count T_PWRUP cycles → INIT.
  - INIT: issue 0x38, 0x38, 0x38, 0x38 (function set: 8-bit, 2 lines, 5x8), then 0x0C (display on, cursor off), 0x01 (clear), 0x06 (entry mode, increment). All with RS = 0. After the last one: init_done = 1 → ADDR1.
  - ADDR1: command 0x80 (DDRAM address 0x00); index = 0 → DATA.
  - DATA: FETCH sub-step waits FETCH_LAT cycles after `index` changes, then latches char_in into lcd_db with RS = 1 and runs a bus write cycle. Then:
    - index 15 → index = 16, go ADDR2.
    - index 31 → pulse frame_done, go ADDR1 (index wraps to 0).
    - otherwise index + 1, stay in DATA.
  - ADDR2: command 0xC0 (DDRAM address 0x40) → DATA at index 16.
- index changes only in the cycle after a bus-write cycle completes. It is stable for at least FETCH_LAT cycles before char_in is sampled.
- char_in is sampled exactly once per position. Upstream changes after sampling are shown next frame.
- Refresh has no gap: ADDR1 follows frame_done directly.
- Counter is 20 bits wide, enough for max(T_PWRUP, T_CLEAR). Counter compares use `count == T-1`; all T parameters must be ≥ 1.
- lcd_rw is constant 0 in every state.

Decomposition:
- Package lcd_pkg:
  - command constants CMD_FUNCSET = 8'h38, CMD_DISPON = 8'h0C, CMD_CLEAR = 8'h01, CMD_ENTRY = 8'h06, CMD_LINE1 = 8'h80, CMD_LINE2 = 8'hC0;
  - FSM state enum (PWR_WAIT, INIT, ADDR1, ADDR2, DATA);
  - counter width constant.
- Sub-module lcd_bus_write:
  - inputs start, rs, byte, is_clear; outputs lcd_rs, lcd_e, lcd_db, done;
  - owns the setup/pulse/hold/exec timing.
- Top-level FSM: sequencing and index generation only.

Test Plan (scaled parameters: T_PWRUP=20, T_SETUP=1, T_EPW=2, T_HOLD=1, T_EXEC=5, T_CLEAR=10, FETCH_LAT=2):
- Release reset → first E rise exactly 20 + 1 cycles later. Bytes in order are 38, 38, 38, 38, 0C, 01, 06 with RS = 0; init_done rises after the 06 write; the gap after 01 is 10 cycles, not 5.
- char_in model of index+0x41 with 1-cycle register latency → DB at E-rise shows 0x80, then 0x41..0x50 (RS = 1), then 0xC0, then 0x51..0x60; frame_done pulses once.
- Two consecutive frames → index wraps 31 → 0; 0x80 is re-sent immediately after frame_done; there are 34 E pulses per frame.
- Bus monitor → RS/DB never change while E is high or within T_HOLD after its fall; lcd_rw is 0 throughout.
- Assert rst with E high mid-data → E, DB, index, init_done are 0 in the same cycle. After release, the full init sequence repeats from PWR_WAIT.
- Change char_in for index 5 after it has been written → the new value first appears on the bus in the next frame.
